// File: rtl/rm_pkg.sv
// Shared constants and types for the rm_* bus selector blocks.
// State encoding and the default bus width live here so every block agrees on them.
package rm_pkg;

  localparam int RM_BUS_W = 8;

  typedef enum logic {
    RM_MUX_IDLE = 1'b0,
    RM_MUX_FULL = 1'b1
  } rm_state_e;

  // Next channel index after v, wrapping at n.
  function automatic int rm_wrap_inc(input int v, input int n);
    return (v + 1) % n;
  endfunction

endpackage

// File: rtl/rm_rr_arbiter.sv
// Combinational rotating-priority arbiter: grants the first requesting channel
// found by searching cyclically upward from ptr.
module rm_rr_arbiter #(
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic [CHANNELS-1:0] req,
  input  logic [SEL_W-1:0]    ptr,
  output logic [SEL_W-1:0]    grant,
  output logic                any
);

  int idx;

  always_comb begin
    grant = '0;
    any   = 1'b0;
    idx   = 0;
    for (int k = 0; k < CHANNELS; k++) begin
      idx = (int'(ptr) + k) % CHANNELS;
      if (!any && req[idx]) begin
        any   = 1'b1;
        grant = SEL_W'(idx);
      end
    end
  end

endmodule

// File: rtl/rm_mux_reg.sv
// Registered N:1 bus selector with valid/ready per channel and a one-entry output register.
// Optional round-robin source selection is built when RM_MUX_RR_EN is defined.
//
// Handshake: a word moves on a rising edge where valid and ready are both high; ready
// never depends on the same channel's valid in fixed mode, and a held word stays put
// (unchanged) until y_valid && y_ready is seen with enable_n low.
module rm_mux_reg
  import rm_pkg::*;
#(
  parameter  int WIDTH    = RM_BUS_W,
  parameter  int CHANNELS = 4,
  localparam int SEL_W    = $clog2(CHANNELS)
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      enable_n,
  input  logic [SEL_W-1:0]          sel,
  input  logic [CHANNELS*WIDTH-1:0] in_data,
  input  logic [CHANNELS-1:0]       in_valid,
  output logic [CHANNELS-1:0]       in_ready,
  output logic [WIDTH-1:0]          y,
  output logic                      y_valid,
  input  logic                      y_ready,
  output logic [SEL_W-1:0]          y_chan
`ifdef RM_MUX_RR_EN
  ,
  input  logic                      rr_mode
`endif
);

  rm_state_e        state_q, state_d;
  logic [WIDTH-1:0] data_q;
  logic [SEL_W-1:0] chan_q;

  logic [SEL_W-1:0] src;
  logic             legal;
  logic             src_valid;
  logic [WIDTH-1:0] src_data;
  logic             slot_open;
  logic             acc;

`ifdef RM_MUX_RR_EN
  logic [SEL_W-1:0] rr_ptr_q;
  logic [SEL_W-1:0] rr_grant;
  logic             rr_any;

  rm_rr_arbiter #(.CHANNELS(CHANNELS)) u_rr_arbiter (
    .req   (in_valid),
    .ptr   (rr_ptr_q),
    .grant (rr_grant),
    .any   (rr_any)
  );

  always_comb begin
    src   = sel;
    legal = (int'(sel) < CHANNELS);
    if (rr_mode) begin
      src   = rr_grant;
      legal = rr_any;
    end
  end

  // Pointer only advances on transfers made in round-robin mode.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr_q <= '0;
    end else if (acc && rr_mode) begin
      rr_ptr_q <= SEL_W'(rm_wrap_inc(int'(src), CHANNELS));
    end
  end
`else
  always_comb begin
    src   = sel;
    legal = (int'(sel) < CHANNELS);
  end
`endif

  // Out-of-range indices match no channel, so they select nothing.
  always_comb begin
    src_valid = 1'b0;
    src_data  = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      if (i == int'(src)) begin
        src_valid = in_valid[i];
        src_data  = in_data[i*WIDTH +: WIDTH];
      end
    end
  end

  assign slot_open = (state_q == RM_MUX_IDLE) || y_ready;
  assign acc       = rst_n && !enable_n && legal && src_valid && slot_open;

  always_comb begin
    in_ready = '0;
    for (int i = 0; i < CHANNELS; i++) begin
      in_ready[i] = rst_n && !enable_n && legal && slot_open && (i == int'(src));
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      RM_MUX_IDLE: if (acc) state_d = RM_MUX_FULL;
      RM_MUX_FULL: begin
        if (acc)                       state_d = RM_MUX_FULL;
        else if (!enable_n && y_ready) state_d = RM_MUX_IDLE;
      end
      default: state_d = RM_MUX_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= RM_MUX_IDLE;
      data_q  <= '0;
      chan_q  <= '0;
    end else begin
      state_q <= state_d;
      if (acc) begin
        data_q <= src_data;
        chan_q <= src;
      end
    end
  end

  // Disabled outputs read as zero while the held word is preserved underneath.
  assign y_valid = (state_q == RM_MUX_FULL) && !enable_n;
  assign y       = y_valid ? data_q : '0;
  assign y_chan  = chan_q;

endmodule

// File: tb/tb_rm_mux_reg.sv
// Self-checking bench for rm_mux_reg: scoreboard on a 4-channel instance plus
// directed out-of-range select checks on a 3-channel instance.
module tb_rm_mux_reg;

  localparam int W  = 8;
  localparam int CH = 4;
  localparam int SW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          enable_n = 1'b1;
  logic [SW-1:0] sel = '0;
  logic [CH*W-1:0] in_data = '0;
  logic [CH-1:0] in_valid = '0;
  logic [CH-1:0] in_ready;
  logic [W-1:0]  y;
  logic          y_valid;
  logic          y_ready = 1'b0;
  logic [SW-1:0] y_chan;
  logic          rr_mode = 1'b0;

  logic          rst3_n = 1'b0;
  logic          enable3_n = 1'b1;
  logic [1:0]    sel3 = '0;
  logic [3*W-1:0] in_data3 = '0;
  logic [2:0]    in_valid3 = '0;
  logic [2:0]    in_ready3;
  logic [W-1:0]  y3;
  logic          y_valid3;
  logic          y_ready3 = 1'b0;
  logic [1:0]    y_chan3;
  logic          rr_mode3 = 1'b0;

  rm_mux_reg #(.WIDTH(W), .CHANNELS(CH)) u_dut (
    .clk(clk), .rst_n(rst_n), .enable_n(enable_n), .sel(sel),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .y(y), .y_valid(y_valid), .y_ready(y_ready), .y_chan(y_chan)
`ifdef RM_MUX_RR_EN
    , .rr_mode(rr_mode)
`endif
  );

  rm_mux_reg #(.WIDTH(W), .CHANNELS(3)) u_dut3 (
    .clk(clk), .rst_n(rst3_n), .enable_n(enable3_n), .sel(sel3),
    .in_data(in_data3), .in_valid(in_valid3), .in_ready(in_ready3),
    .y(y3), .y_valid(y_valid3), .y_ready(y_ready3), .y_chan(y_chan3)
`ifdef RM_MUX_RR_EN
    , .rr_mode(rr_mode3)
`endif
  );

  // clock / reset
  always #5 clk = ~clk;

  // scoreboard state: each entry is {channel, data}
  logic [SW+W-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;
  int mon_held = 0;
  bit mon_on = 0;
  bit pending_reset = 0;
  int rr_ptr = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // driver: apply one cycle of stimulus, predict the result, check in_ready
  task automatic drive(input bit r, input bit en_n, input logic [SW-1:0] s,
                       input logic [CH-1:0] v, input logic [CH*W-1:0] d,
                       input bit yr, input bit rr);
    int held, src;
    bit legal, open, acc;
    logic [CH-1:0] exp_rdy;
    @(posedge clk);
    #2;
    if (pending_reset) begin
      exp_q.delete();
      rr_ptr = 0;
      pending_reset = 0;
    end
    rst_n = r; enable_n = en_n; sel = s; in_valid = v; in_data = d;
    y_ready = yr; rr_mode = rr;
    held = exp_q.size();
    src = int'(s);
    legal = 1'b1;
`ifdef RM_MUX_RR_EN
    if (rr) begin
      legal = 1'b0;
      for (int k = 0; k < CH; k++) begin
        if (!legal && v[(rr_ptr + k) % CH]) begin
          legal = 1'b1;
          src = (rr_ptr + k) % CH;
        end
      end
    end
`endif
    open = (held == 0) || yr;
    acc = r && !en_n && legal && v[src] && open;
    exp_rdy = '0;
    if (r && !en_n && legal && open) exp_rdy[src] = 1'b1;
    #1;
    chk("in_ready", 32'(in_ready), 32'(exp_rdy));
    if (acc) begin
      exp_q.push_back({SW'(src), d[src*W +: W]});
      if (rr) rr_ptr = (src + 1) % CH;
    end
    mon_held = held;
    mon_on = 1'b1;
    if (!r) pending_reset = 1'b1;
  endtask

  // monitor: compare the presented word against the scoreboard head
  always @(negedge clk) begin
    logic [SW+W-1:0] front;
    if (mon_on && mon_held > 0 && !enable_n) begin
      front = exp_q[0];
      chk("y_valid", 32'(y_valid), 32'd1);
      chk("y", 32'(y), 32'(front[W-1:0]));
      chk("y_chan", 32'(y_chan), 32'(front[SW+W-1:W]));
      if (y_ready) front = exp_q.pop_front();
    end else if (mon_on) begin
      chk("y_valid_idle", 32'(y_valid), 32'd0);
      chk("y_masked", 32'(y), 32'd0);
    end
  end

  initial begin
    logic [CH*W-1:0] d;
    // reset
    drive(0, 1, 0, '0, '0, 0, 0);
    drive(0, 1, 0, '0, '0, 0, 0);
    @(posedge clk); #3;
    chk("reset_y_chan", 32'(y_chan), 32'd0);

    // fixed select, single transfer
    drive(1, 0, 2'd1, 4'b0011, {8'h00, 8'h00, 8'h55, 8'hAA}, 1, 0);
    drive(1, 0, 2'd1, 4'b0000, '0, 1, 0);
    drive(1, 0, 2'd1, 4'b0000, '0, 1, 0);

    // back-to-back streaming on channel 2
    for (int i = 0; i < 4; i++) begin
      d = '0;
      d[2*W +: W] = 8'(8'h10 + i);
      drive(1, 0, 2'd2, 4'b0100, d, 1, 0);
    end
    drive(1, 0, 2'd2, 4'b0000, '0, 1, 0);

    // backpressure: F0 held for 3 cycles with 0F waiting
    drive(1, 0, 2'd0, 4'b0001, {24'h0, 8'hF0}, 1, 0);
    for (int i = 0; i < 3; i++) drive(1, 0, 2'd0, 4'b0001, {24'h0, 8'h0F}, 0, 0);
    drive(1, 0, 2'd0, 4'b0001, {24'h0, 8'h0F}, 1, 0);
    drive(1, 0, 2'd0, 4'b0000, '0, 1, 0);

    // disable while full
    drive(1, 0, 2'd3, 4'b1000, {8'hAA, 24'h0}, 0, 0);
    drive(1, 1, 2'd3, 4'b1111, {8'h11, 24'h0}, 1, 0);
    drive(1, 1, 2'd3, 4'b1111, {8'h22, 24'h0}, 1, 0);
    drive(1, 0, 2'd3, 4'b0000, '0, 1, 0);
    drive(1, 0, 2'd3, 4'b0000, '0, 1, 0);

    // reset with a word held
    drive(1, 0, 2'd1, 4'b0010, {16'h0, 8'h77, 8'h0}, 1, 0);
    drive(0, 0, 2'd1, 4'b0010, {16'h0, 8'h66, 8'h0}, 0, 0);
    drive(1, 0, 2'd1, 4'b0000, '0, 0, 0);

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      d = {$urandom(), $urandom()};
      drive(($urandom_range(0, 49) != 0), ($urandom_range(0, 4) == 0),
            SW'($urandom_range(0, CH - 1)), CH'($urandom_range(0, 15)), d,
            ($urandom_range(0, 2) != 0), 0);
    end

`ifdef RM_MUX_RR_EN
    drive(0, 0, 0, '0, '0, 0, 0);
    for (int i = 0; i < 6; i++) begin
      d = {$urandom(), $urandom()};
      drive(1, 0, 2'd2, 4'b1011, d, 1, 1);
    end
    for (int i = 0; i < 200; i++) begin
      d = {$urandom(), $urandom()};
      drive(1, ($urandom_range(0, 5) == 0), SW'($urandom_range(0, CH - 1)),
            CH'($urandom_range(0, 15)), d, ($urandom_range(0, 2) != 0),
            bit'($urandom_range(0, 1)));
    end
`endif
    drive(1, 0, 0, '0, '0, 1, 0);
    drive(1, 0, 0, '0, '0, 1, 0);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    // 3-channel instance: out-of-range select
    @(posedge clk); #2;
    rst3_n = 1'b1; enable3_n = 1'b0; sel3 = 2'd3; in_valid3 = 3'b111;
    in_data3 = {8'h33, 8'h22, 8'h11}; y_ready3 = 1'b1;
    #1 chk("c3_illegal_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    chk("c3_illegal_nocap", 32'(y_valid3), 32'd0);
    #1 sel3 = 2'd2;
    #1 chk("c3_legal_ready", 32'(in_ready3), 32'b100);
    @(posedge clk); #1;
    chk("c3_cap_y", 32'(y3), 32'h33);
    chk("c3_cap_chan", 32'(y_chan3), 32'd2);
    #1 sel3 = 2'd3; y_ready3 = 1'b0;
    @(posedge clk); #1;
    chk("c3_hold_y", 32'(y3), 32'h33);
    chk("c3_hold_chan", 32'(y_chan3), 32'd2);
    chk("c3_hold_valid", 32'(y_valid3), 32'd1);
    #1 y_ready3 = 1'b1;
    @(posedge clk); #1;
    chk("c3_drain", 32'(y_valid3), 32'd0);
    #1 sel3 = 2'd1;
    @(posedge clk); #1;
    chk("c3_cap2_y", 32'(y3), 32'h22);
    #1 rst3_n = 1'b0;
    #1 chk("c3_rst_ready", 32'(in_ready3), 32'd0);
    @(posedge clk); #1;
    chk("c3_rst_y", 32'(y3), 32'd0);
    chk("c3_rst_valid", 32'(y_valid3), 32'd0);
    chk("c3_rst_chan", 32'(y_chan3), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
